// File: rtl/pipeline_ctrl.sv
// pipeline_ctrl
//   Controller for the 5-stage MIPS datapath. It drives every stage-register
//   enable and flush. It also resolves load-use stalls, EX-operand forwarding
//   and redirect flushes. A run/step/drain/halt state machine and an
//   active-cycle counter sit on top of that.
//
// Ports
//   i_clk, i_rst            clock, synchronous active-high reset
//   i_mode, i_start         0 = run / 1 = step, start pulse (IDLE only)
//   i_id_*                  ID-stage halt flag and source registers
//   i_ex_*                  EX-stage sources, destination, write/load flags,
//                           and the taken-branch/jump redirect
//   i_ma_*, i_wb_*          MA/WB destination and write enable (forwarding)
//   o_*_en                  stage-register enables (PC, IF/ID, ID/EX, EX/MA, MA/WB)
//   o_if_id_flush,
//   o_id_ex_flush           load a NOP into the register on the next edge
//   o_fwd_a, o_fwd_b        EX operand source: 00 regfile, 01 MA, 10 WB
//   o_state                 0 IDLE, 1 RUN, 2 STEP, 3 DRAIN, 4 HALTED
//   o_cycle_cnt             saturating count of active cycles
//   o_halted                high in HALTED
module pipeline_ctrl #(
  parameter int NREG_BITS  = 5,
  parameter int CNT_BITS   = 32,
  parameter int LOAD_LAT   = 1,
  parameter int PIPE_DEPTH = 5
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_mode,
  input  logic                 i_start,
  input  logic                 i_id_halt,
  input  logic [NREG_BITS-1:0] i_id_rs,
  input  logic [NREG_BITS-1:0] i_id_rt,
  input  logic                 i_id_uses_rt,
  input  logic [NREG_BITS-1:0] i_ex_rs,
  input  logic [NREG_BITS-1:0] i_ex_rt,
  input  logic [NREG_BITS-1:0] i_ex_rd,
  input  logic                 i_ex_reg_wr_en,
  input  logic                 i_ex_mem_rd,
  input  logic                 i_ex_redirect,
  input  logic [NREG_BITS-1:0] i_ma_rd,
  input  logic                 i_ma_reg_wr_en,
  input  logic [NREG_BITS-1:0] i_wb_rd,
  input  logic                 i_wb_reg_wr_en,
  output logic                 o_pc_en,
  output logic                 o_if_id_en,
  output logic                 o_id_ex_en,
  output logic                 o_ex_ma_en,
  output logic                 o_ma_wb_en,
  output logic                 o_if_id_flush,
  output logic                 o_id_ex_flush,
  output logic [1:0]           o_fwd_a,
  output logic [1:0]           o_fwd_b,
  output logic [2:0]           o_state,
  output logic [CNT_BITS-1:0]  o_cycle_cnt,
  output logic                 o_halted
);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_RUN    = 3'd1,
    ST_STEP   = 3'd2,
    ST_DRAIN  = 3'd3,
    ST_HALTED = 3'd4
  } state_e;

  // The stall counter only has to hold the extra cycles beyond the first.
  localparam int STALL_W = (LOAD_LAT > 1) ? $clog2(LOAD_LAT) : 1;
  localparam logic [STALL_W-1:0] STALL_LOAD = STALL_W'(LOAD_LAT - 1);
  // DRAIN ends once the counter reaches zero, so load one less than its length.
  localparam int DRAIN_W = (PIPE_DEPTH > 3) ? $clog2(PIPE_DEPTH) : 1;
  localparam logic [DRAIN_W-1:0] DRAIN_LOAD = DRAIN_W'(PIPE_DEPTH - 3);

  state_e               state_q, state_d;
  logic [STALL_W-1:0]   stall_cnt_q, stall_cnt_d;
  logic [DRAIN_W-1:0]   drain_cnt_q, drain_cnt_d;
  logic [CNT_BITS-1:0]  cycle_cnt_q, cycle_cnt_d;

  logic load_use;
  logic stall_now;
  logic halt_acc;

  function automatic logic [CNT_BITS-1:0] sat_inc(input logic [CNT_BITS-1:0] v);
    return (v == {CNT_BITS{1'b1}}) ? v : v + 1'b1;
  endfunction

  function automatic logic [1:0] fwd_sel(input logic [NREG_BITS-1:0] src);
    logic [1:0] sel;
    sel = 2'b00;
    // MA holds the younger result, so it takes priority over WB.
    if (i_ma_reg_wr_en && (i_ma_rd != '0) && (i_ma_rd == src))
      sel = 2'b01;
    else if (i_wb_reg_wr_en && (i_wb_rd != '0) && (i_wb_rd == src))
      sel = 2'b10;
    return sel;
  endfunction

  assign o_fwd_a = fwd_sel(i_ex_rs);
  assign o_fwd_b = fwd_sel(i_ex_rt);

  assign load_use = i_ex_mem_rd && i_ex_reg_wr_en && (i_ex_rd != '0) &&
                    ((i_ex_rd == i_id_rs) || (i_id_uses_rt && (i_ex_rd == i_id_rt)));

  always_comb begin
    state_d       = state_q;
    stall_cnt_d   = stall_cnt_q;
    drain_cnt_d   = drain_cnt_q;
    cycle_cnt_d   = cycle_cnt_q;
    o_pc_en       = 1'b0;
    o_if_id_en    = 1'b0;
    o_id_ex_en    = 1'b0;
    o_ex_ma_en    = 1'b0;
    o_ma_wb_en    = 1'b0;
    o_if_id_flush = 1'b0;
    o_id_ex_flush = 1'b0;
    stall_now     = 1'b0;
    halt_acc      = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (i_start) state_d = i_mode ? ST_STEP : ST_RUN;
      end

      ST_RUN, ST_STEP, ST_DRAIN: begin
        o_pc_en     = 1'b1;
        o_if_id_en  = 1'b1;
        o_id_ex_en  = 1'b1;
        o_ex_ma_en  = 1'b1;
        o_ma_wb_en  = 1'b1;
        cycle_cnt_d = sat_inc(cycle_cnt_q);

        // A redirect squashes the dependent instruction anyway, so any
        // pending stall is dropped.
        if (i_ex_redirect) begin
          o_if_id_flush = 1'b1;
          o_id_ex_flush = 1'b1;
          stall_cnt_d   = '0;
        end else if (stall_cnt_q != '0) begin
          stall_now   = 1'b1;
          stall_cnt_d = stall_cnt_q - 1'b1;
        end else if (load_use) begin
          stall_now   = 1'b1;
          stall_cnt_d = STALL_LOAD;
        end

        if (stall_now) begin
          o_pc_en       = 1'b0;
          o_if_id_en    = 1'b0;
          o_id_ex_flush = 1'b1;
        end

        // HALT is only taken from a clean ID slot; it then travels on as a NOP.
        halt_acc = (state_q != ST_DRAIN) && i_id_halt && !i_ex_redirect && !stall_now;

        if (halt_acc) begin
          o_pc_en       = 1'b0;
          o_if_id_flush = 1'b1;
          state_d       = ST_DRAIN;
          drain_cnt_d   = DRAIN_LOAD;
        end else if (state_q == ST_STEP) begin
          state_d = ST_IDLE;
        end

        if (state_q == ST_DRAIN) begin
          o_pc_en       = 1'b0;
          o_if_id_flush = 1'b1;
          if (drain_cnt_q == '0) state_d = ST_HALTED;
          else                   drain_cnt_d = drain_cnt_q - 1'b1;
        end
      end

      ST_HALTED: begin
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q     <= ST_IDLE;
      stall_cnt_q <= '0;
      drain_cnt_q <= '0;
      cycle_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      stall_cnt_q <= stall_cnt_d;
      drain_cnt_q <= drain_cnt_d;
      cycle_cnt_q <= cycle_cnt_d;
    end
  end

  assign o_state     = state_q;
  assign o_cycle_cnt = cycle_cnt_q;
  assign o_halted    = (state_q == ST_HALTED);

endmodule

// File: tb/tb_pipeline_ctrl.sv
module tb_pipeline_ctrl;

  localparam int NB = 5;
  localparam int CB = 32;

  logic          clk;
  logic          rst;
  logic          mode, start, id_halt, id_uses_rt;
  logic [NB-1:0] id_rs, id_rt, ex_rs, ex_rt, ex_rd, ma_rd, wb_rd;
  logic          ex_reg_wr_en, ex_mem_rd, ex_redirect, ma_reg_wr_en, wb_reg_wr_en;
  logic          pc_en, if_id_en, id_ex_en, ex_ma_en, ma_wb_en;
  logic          if_id_flush, id_ex_flush;
  logic [1:0]    fwd_a, fwd_b;
  logic [2:0]    state;
  logic [CB-1:0] cycle_cnt;
  logic          halted;

  int n_tests = 0;
  int n_fail  = 0;

  pipeline_ctrl #(
    .NREG_BITS (NB),
    .CNT_BITS  (CB),
    .LOAD_LAT  (2),
    .PIPE_DEPTH(5)
  ) dut (
    .i_clk          (clk),
    .i_rst          (rst),
    .i_mode         (mode),
    .i_start        (start),
    .i_id_halt      (id_halt),
    .i_id_rs        (id_rs),
    .i_id_rt        (id_rt),
    .i_id_uses_rt   (id_uses_rt),
    .i_ex_rs        (ex_rs),
    .i_ex_rt        (ex_rt),
    .i_ex_rd        (ex_rd),
    .i_ex_reg_wr_en (ex_reg_wr_en),
    .i_ex_mem_rd    (ex_mem_rd),
    .i_ex_redirect  (ex_redirect),
    .i_ma_rd        (ma_rd),
    .i_ma_reg_wr_en (ma_reg_wr_en),
    .i_wb_rd        (wb_rd),
    .i_wb_reg_wr_en (wb_reg_wr_en),
    .o_pc_en        (pc_en),
    .o_if_id_en     (if_id_en),
    .o_id_ex_en     (id_ex_en),
    .o_ex_ma_en     (ex_ma_en),
    .o_ma_wb_en     (ma_wb_en),
    .o_if_id_flush  (if_id_flush),
    .o_id_ex_flush  (id_ex_flush),
    .o_fwd_a        (fwd_a),
    .o_fwd_b        (fwd_b),
    .o_state        (state),
    .o_cycle_cnt    (cycle_cnt),
    .o_halted       (halted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one edge, then let inputs/outputs settle well away from it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    mode = 0; start = 0; id_halt = 0; id_uses_rt = 0;
    id_rs = '0; id_rt = '0; ex_rs = '0; ex_rt = '0; ex_rd = '0;
    ma_rd = '0; wb_rd = '0;
    ex_reg_wr_en = 0; ex_mem_rd = 0; ex_redirect = 0;
    ma_reg_wr_en = 0; wb_reg_wr_en = 0;
  endtask

  function automatic logic [4:0] ens();
    return {pc_en, if_id_en, id_ex_en, ex_ma_en, ma_wb_en};
  endfunction

  initial begin
    clear_inputs();
    rst = 1;
    tick(); tick();
    rst = 0;
    #1;
    chk("rst_state", state, 3'd0);
    chk("rst_cnt", cycle_cnt, 0);
    chk("rst_ens", ens(), 5'b00000);
    chk("rst_flush", {if_id_flush, id_ex_flush}, 2'b00);
    chk("rst_halted", halted, 1'b0);

    // Forwarding is combinational, so check it in IDLE.
    ex_rs = 5; ma_rd = 5; wb_rd = 5; ma_reg_wr_en = 1; wb_reg_wr_en = 1; #1;
    chk("fwd_a_ma", fwd_a, 2'b01);
    ma_reg_wr_en = 0; #1;
    chk("fwd_a_wb", fwd_a, 2'b10);
    ex_rt = 7; wb_rd = 7; ma_rd = 7; ma_reg_wr_en = 1; #1;
    chk("fwd_b_ma", fwd_b, 2'b01);
    chk("fwd_a_none", fwd_a, 2'b00);
    ex_rs = 0; ex_rt = 0; ma_rd = 0; wb_rd = 0; #1;
    chk("fwd_a_r0", fwd_a, 2'b00);
    chk("fwd_b_r0", fwd_b, 2'b00);
    clear_inputs(); #1;

    // Run start.
    start = 1; tick(); start = 0; #1;
    chk("run_state", state, 3'd1);
    chk("run_ens", ens(), 5'b11111);
    chk("run_cnt0", cycle_cnt, 0);
    tick();
    chk("run_cnt1", cycle_cnt, 1);

    // Load-use with LOAD_LAT=2: two stall cycles.
    ex_rd = 3; id_rs = 3; ex_mem_rd = 1; ex_reg_wr_en = 1; #1;
    chk("lu1_pc", pc_en, 1'b0);
    chk("lu1_ifid_en", if_id_en, 1'b0);
    chk("lu1_flush", id_ex_flush, 1'b1);
    tick();
    clear_inputs(); #1;
    chk("lu2_pc", pc_en, 1'b0);
    chk("lu2_flush", id_ex_flush, 1'b1);
    tick();
    chk("lu3_pc", pc_en, 1'b1);
    chk("lu3_flush", id_ex_flush, 1'b0);
    chk("lu_cnt", cycle_cnt, 3);

    // Destination r0 never stalls.
    ex_rd = 0; id_rs = 0; ex_mem_rd = 1; ex_reg_wr_en = 1; #1;
    chk("lu_r0_pc", pc_en, 1'b1);
    tick(); // cnt 4
    // rt match only counts when rt is read.
    ex_rd = 4; id_rs = 9; id_rt = 4; id_uses_rt = 0; #1;
    chk("lu_rt_unused", pc_en, 1'b1);
    id_uses_rt = 1; #1;
    chk("lu_rt_used", pc_en, 1'b0);
    ex_redirect = 1; #1;
    chk("redir_flush", {if_id_flush, id_ex_flush}, 2'b11);
    chk("redir_en", {pc_en, if_id_en}, 2'b11);
    tick(); // cnt 5
    clear_inputs(); #1;
    chk("redir_nostall_pc", pc_en, 1'b1);
    chk("redir_nostall_fl", id_ex_flush, 1'b0);

    // HALT in RUN, then drain 3 cycles.
    id_halt = 1; #1;
    chk("halt_acc_pc", pc_en, 1'b0);
    chk("halt_acc_fl", if_id_flush, 1'b1);
    chk("halt_acc_idex", id_ex_en, 1'b1);
    tick(); // cnt 6
    id_halt = 0; #1;
    chk("drain1_state", state, 3'd3);
    chk("drain1_pcfl", {pc_en, if_id_flush, if_id_en}, 3'b011);
    tick();
    chk("drain2_state", state, 3'd3);
    tick();
    chk("drain3_state", state, 3'd3);
    chk("drain3_halted", halted, 1'b0);
    tick();
    chk("halted_state", state, 3'd4);
    chk("halted_flag", halted, 1'b1);
    chk("halted_cnt", cycle_cnt, 9);
    chk("halted_ens", ens(), 5'b00000);
    start = 1; tick(); start = 0; tick();
    chk("halted_ignore", state, 3'd4);
    chk("halted_cnt_hold", cycle_cnt, 9);
    rst = 1; tick(); rst = 0; #1;
    chk("halt_rst_state", state, 3'd0);
    chk("halt_rst_cnt", cycle_cnt, 0);
    chk("halt_rst_halted", halted, 1'b0);

    // Step mode: three single active cycles.
    for (int i = 0; i < 3; i++) begin
      mode = 1; start = 1; tick(); start = 0; #1;
      chk("step_state", state, 3'd2);
      chk("step_ens", ens(), 5'b11111);
      tick();
      chk("step_back_idle", state, 3'd0);
      chk("step_cnt", cycle_cnt, i + 1);
    end

    // Reset in the middle of a stall clears everything.
    mode = 0; start = 1; tick(); start = 0;
    ex_rd = 3; id_rs = 3; ex_mem_rd = 1; ex_reg_wr_en = 1;
    tick();
    clear_inputs();
    rst = 1; tick(); rst = 0; #1;
    chk("midstall_rst_state", state, 3'd0);
    chk("midstall_rst_cnt", cycle_cnt, 0);
    start = 1; tick(); start = 0; #1;
    chk("post_rst_nostall", pc_en, 1'b1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/pipeline_ctrl.md
# pipeline_ctrl

Parametrised pipeline controller for the 5-stage MIPS datapath. It sits beside the stage tops and pipeline registers and drives every stage-register enable and flush. It also resolves load-use hazards (stall), EX-operand forwarding and taken branch/jump flushes. Its run/step/halt state machine lets the core be stepped one cycle at a time, drained on HALT, and profiled with a cycle counter.

## Interface
- NREG_BITS, 5, register-index width
- CNT_BITS, 32, cycle-counter width
- LOAD_LAT, 1, stall cycles inserted per load-use hazard (>=1)
- PIPE_DEPTH, 5, stage count; drain length is PIPE_DEPTH-2 cycles
- i_clk  in  1  clock; all state updates on rising edge
- i_rst  in  1  reset, synchronous, active-high
- i_mode  in  1  0 = run, 1 = step; sampled only in IDLE
- i_start  in  1  pulse: start run, or execute one step
- i_id_halt  in  1  HALT instruction decoded in ID
- i_id_rs, i_id_rt  in  NREG_BITS  ID source registers
- i_id_uses_rt  in  1  ID instruction reads rt
- i_ex_rs, i_ex_rt  in  NREG_BITS  EX source registers (forwarding)
- i_ex_rd  in  NREG_BITS  EX destination register
- i_ex_reg_wr_en, i_ex_mem_rd  in  1  EX writes a register / EX is a load
- i_ex_redirect  in  1  EX resolved a taken branch or jump
- i_ma_rd  in  NREG_BITS; i_ma_reg_wr_en  in  1  MA destination / write enable
- i_wb_rd  in  NREG_BITS; i_wb_reg_wr_en  in  1  WB destination / write enable
- o_pc_en, o_if_id_en, o_id_ex_en, o_ex_ma_en, o_ma_wb_en  out  1  stage-register enables
- o_if_id_flush, o_id_ex_flush  out  1  load NOP into register on next edge
- o_fwd_a, o_fwd_b  out  2  EX operand source: 00 regfile, 01 MA, 10 WB
- o_state  out  3  0 IDLE, 1 RUN, 2 STEP, 3 DRAIN, 4 HALTED
- o_cycle_cnt  out  CNT_BITS  active-cycle count
- o_halted  out  1  high in HALTED

## Operation
- States:
  - IDLE: all enables 0.
    - i_start with i_mode=0 goes to RUN.
    - i_start with i_mode=1 goes to STEP.
  - RUN: free-running until halt.
  - STEP: exactly one active cycle, then IDLE (unless halt, see below).
  - DRAIN: runs PIPE_DEPTH-2 cycles regardless of i_mode, then HALTED.
  - HALTED: absorbing until i_rst.
- i_start is ignored outside IDLE.
- Active states (RUN, STEP, DRAIN) enable every stage, except as modified below.
- Load-use hazard in RUN or STEP:
  - Condition: i_ex_mem_rd & i_ex_reg_wr_en & i_ex_rd!=0 & (i_ex_rd==i_id_rs | (i_id_uses_rt & i_ex_rd==i_id_rt)).
  - Response: o_pc_en=0, o_if_id_en=0, o_id_ex_flush=1.
  - A stall counter is loaded with LOAD_LAT-1.
  - While the counter is nonzero, stall unconditionally and decrement.
- Redirect:
  - i_ex_redirect gives o_if_id_flush=1 and o_id_ex_flush=1, with o_pc_en=1 and o_if_id_en=1.
  - Redirect wins over stall and clears the stall counter.
- Halt:
  - i_id_halt is accepted only when no stall or redirect is active in that cycle.
  - Acceptance cycle: o_pc_en=0, o_if_id_flush=1. The HALT itself moves on as a NOP.
  - Next state DRAIN. A HALT seen in STEP also goes to DRAIN.
- DRAIN: o_pc_en=0 and o_if_id_flush=1 every cycle; the other enables are 1; hazards are still evaluated.
- Forwarding (combinational, driven in every state):
  - o_fwd_a=01 if i_ma_reg_wr_en & i_ma_rd!=0 & i_ma_rd==i_ex_rs.
  - Otherwise o_fwd_a=10 if the same condition holds for WB.
  - Otherwise 00.
  - o_fwd_b is identical using i_ex_rt.
  - MA has priority over WB. Register 0 is never forwarded.
- o_cycle_cnt increments in every RUN/STEP/DRAIN cycle and saturates at all-ones.

## Timing
- Reset values: state IDLE, all enables 0, all flushes 0, o_cycle_cnt 0, o_halted 0, stall counter 0. o_fwd_* follow inputs.
- i_rst mid-RUN, mid-DRAIN or mid-stall: next cycle is IDLE and all counters are cleared.
- Enables and flushes are combinational from state and current inputs; they take effect on the same edge that moves to the next state.
- i_start to first active cycle: 1 cycle. IDLE to STEP to IDLE spans exactly 1 active cycle.
- HALT acceptance to o_halted=1: 1 + (PIPE_DEPTH-2) cycles, i.e. 4 edges at default.
- A load-use stall costs exactly LOAD_LAT cycles.

## Test plan
- Reset, then i_mode=0 with an i_start pulse: state 1 next cycle; o_cycle_cnt=1 after the first active edge; all enables 1.
- Load-use with LOAD_LAT=2 (i_ex_rd=3, i_id_rs=3, i_ex_mem_rd=1): o_pc_en=0 and o_id_ex_flush=1 for exactly 2 cycles. With i_ex_rd=0: no stall.
- Forwarding:
  - i_ex_rs=5, i_ma_rd=5, i_wb_rd=5, both writes on: o_fwd_a=01.
  - Same with i_ma_reg_wr_en=0: o_fwd_a=10.
  - Register 0 in all fields: o_fwd_a=00.
- Redirect coincident with a load-use hazard: both flushes 1, o_pc_en=1, no stall in the following cycle.
- Step mode: three i_start pulses give o_cycle_cnt=3, with state returning to 0 between pulses.
- i_id_halt in RUN: o_pc_en=0 thereafter, DRAIN for 3 cycles, then o_halted=1 and o_state=4. i_start is then ignored. i_rst returns to state 0 with o_cycle_cnt=0.
